agc_fetch_decode: RTL and testbench
===================================

Name: agc_fetch_decode

Overview:
- Instruction fetch/decode stage directly upstream of the AGC control unit.
- Owns the 12-bit program counter and reads 15-bit words from memory.
- Folds EXTEND (TC 6) into an extracode flag and applies pending INDEX values to the next word.
- Presents decoded fields (opcode, QC, peripheral bit, Addr12, Addr10) through a valid/ready handshake; detects the halt word.

Parameters:
- RESET_PC, 12'h800, PC value loaded on reset (octal 4000 start address).
- EXTEND_WORD, 15'h0006, word treated as EXTEND (TC 6).
- HALT_ADDR, 12'hFFF, Addr12 which, together with opcode 3'b111 and extracode=0, means halt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  12  fetch address.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  15  read data, valid with mem_rvalid.
- mem_rvalid  in  1  read response, at least 1 cycle after mem_rd.
- pc_load  in  1  control unit redirect (TC, CCS skip, TS overflow skip).
- pc_load_val  in  12  redirect target.
- index_load  in  1  INDEX executed; capture index_val.
- index_val  in  15  value added to next issued word.
- issue_valid  out  1  decoded instruction available.
- issue_ready  in  1  control unit accepts instruction.
- opcode  out  3  word[14:12].
- qc  out  2  word[11:10].
- periph  out  1  word[9].
- addr12  out  12  word[11:0].
- addr10  out  10  word[9:0].
- extracode  out  1  instruction was preceded by EXTEND.
- instr_pc  out  12  address the instruction was fetched from.
- halt  out  1  halt word decoded; sticky until reset.

Behaviour:
- Reset (async, any state):
  - state=FETCH, pc=RESET_PC.
  - mem_rd=0, mem_addr=0, issue_valid=0, halt=0.
  - All decoded outputs and instr_pc = 0.
  - ext_pending=0, idx_pending=0, idx_reg=0, drop=0.
  - Reset mid-read: late mem_rvalid responses are not tracked and are ignored while state=FETCH.
- All outputs are registered.
- FSM states: FETCH, WAIT, DECODE, ISSUE, HALT.
- FETCH: mem_rd=1, mem_addr=pc for exactly one cycle, then go to WAIT.
- WAIT: hold until mem_rvalid; capture the word into a raw register, then go to DECODE.
  - If drop=1, discard the word, clear drop, and return to FETCH.
- DECODE (one cycle):
  - If idx_pending and the raw word != EXTEND_WORD: word = raw + idx_reg, 15-bit modulo 2^15 (carry discarded); clear idx_pending.
  - Word == EXTEND_WORD: set ext_pending, pc=pc+1, go to FETCH; nothing is issued. idx_pending is preserved across EXTEND.
  - Word is halt (opcode 7, addr12=HALT_ADDR, ext_pending=0): go to HALT, halt=1.
  - Otherwise: load output fields from the word, extracode=ext_pending, instr_pc=pc, issue_valid=1, go to ISSUE.
- ISSUE: hold issue_valid and fields stable until issue_ready.
  - On handshake: issue_valid=0, ext_pending=0, pc=pc+1, go to FETCH.
- HALT: no further fetches or issues; only rst exits.
- pc_load (priority over normal PC update, any state except HALT):
  - pc = pc_load_val.
  - In WAIT: set drop.
  - In ISSUE without handshake: cancel issue (issue_valid=0 next cycle), go to FETCH.
  - In ISSUE with simultaneous handshake: instruction counts as issued (ext_pending cleared), then PC = pc_load_val.
  - In DECODE: the decoded result is discarded and the FSM returns to FETCH (an EXTEND decoded that cycle still sets ext_pending).
  - ext_pending and idx_pending are never cleared by pc_load.
- index_load: idx_reg=index_val, idx_pending=1. It is applied to the next non-EXTEND word decoded after the capture.
- PC wraps from 12'hFFF to 12'h000.
- Minimum latency: mem_rd in cycle 0, mem_rvalid in cycle 1, decode in cycle 2, issue_valid=1 in cycle 3.
- At most one outstanding memory read at any time.

Decomposition:
- Shared package agc_pkg:
  - opcode localparams: TC=0, CCS/DV=1, CS=4, INDEX/XCH/TS=5, AD/SU=6, MASK/MP=7.
  - Special addresses: A=0, Q=1, Z=2, L=3.
  - Constants EXTEND_WORD and HALT_ADDR.
  - FSM state encoding.
- One natural sub-module: agc_word_decode. It is purely combinational: word in, returns opcode/qc/periph/addr12/addr10 and is_extend/is_halt flags. FSM, PC and index logic stay in the top module.

Test Plan:
- Reset, memory returns 15'o30012 at PC 12'h800 with 1-cycle latency, issue_ready=1 -> mem_rd at cycle 0 with mem_addr=12'h800; issue_valid at cycle 3 with opcode=3, addr12=12'h00A, instr_pc=12'h800, extracode=0; next fetch at 12'h801.
- Word at 12'h800 = 15'h0006, word at 12'h801 = 15'h6010 -> single issue: opcode=6, extracode=1, instr_pc=12'h801; following instruction has extracode=0.
- index_load with index_val=15'h0005, next word 15'h6010 -> issued addr12=12'h015; the subsequent word is issued unmodified.
- index_load 15'h0001 applied to raw word 15'h7FFF -> issued word 15'h0000 (modulo wrap). Raw word 15'h7FFF without a pending index -> halt=1 and no fetches afterward.
- pc_load to 12'h123 while in WAIT, with the response arriving 3 cycles later -> that response is dropped; next mem_rd has mem_addr=12'h123 and only that word is issued.
- Hold issue_ready=0 for 5 cycles -> issue_valid and all fields stable. Then pc_load(12'h050) together with issue_ready -> exactly one issue; next fetch at 12'h050. Assert rst mid-WAIT -> all outputs return to 0 immediately and fetch restarts at 12'h800.

Source files
------------

// File: rtl/agc_fetch_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : agc_pkg
// Description : Shared opcodes, special addresses, fetch constants and FSM
//               encoding for the AGC fetch/decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package agc_pkg;

    localparam logic [2:0]  C_OP_TC    = 3'd0;
    localparam logic [2:0]  C_OP_CCS   = 3'd1;
    localparam logic [2:0]  C_OP_CS    = 3'd4;
    localparam logic [2:0]  C_OP_INDEX = 3'd5;
    localparam logic [2:0]  C_OP_AD    = 3'd6;
    localparam logic [2:0]  C_OP_MASK  = 3'd7;

    localparam logic [11:0] C_ADDR_A   = 12'd0;
    localparam logic [11:0] C_ADDR_Q   = 12'd1;
    localparam logic [11:0] C_ADDR_Z   = 12'd2;
    localparam logic [11:0] C_ADDR_L   = 12'd3;

    localparam logic [14:0] C_EXTEND_WORD = 15'h0006;
    localparam logic [11:0] C_HALT_ADDR   = 12'hFFF;
    localparam logic [11:0] C_RESET_PC    = 12'h800;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  qc;
        logic        periph;
        logic [11:0] addr12;
        logic [9:0]  addr10;
    } fields_t;

    // INDEX adds into the whole word; the carry out of bit 14 is discarded.
    function automatic logic [14:0] apply_index(input logic [14:0] raw,
                                                input logic [14:0] idx);
        return raw + idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/agc_fetch_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : agc_fetch_decode_if
// Description : Memory, redirect/index and issue signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface agc_fetch_decode_if;

    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [14:0] mem_rdata;
    logic        mem_rvalid;

    logic        pc_load;
    logic [11:0] pc_load_val;
    logic        index_load;
    logic [14:0] index_val;

    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic        periph;
    logic [11:0] addr12;
    logic [9:0]  addr10;
    logic        extracode;
    logic [11:0] instr_pc;
    logic        halt;

    modport master (
        output mem_addr, mem_rd,
        input  mem_rdata, mem_rvalid,
        input  pc_load, pc_load_val, index_load, index_val,
        output issue_valid,
        input  issue_ready,
        output opcode, qc, periph, addr12, addr10, extracode, instr_pc, halt
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_rdata, mem_rvalid,
        output pc_load, pc_load_val, index_load, index_val,
        input  issue_valid,
        output issue_ready,
        input  opcode, qc, periph, addr12, addr10, extracode, instr_pc, halt
    );

endinterface
`default_nettype wire

// File: rtl/agc_fetch_decode_word_decode.sv
`default_nettype none
// ============================================================================
// Module      : agc_word_decode
// Description : Combinational split of a 15-bit AGC word into its fields,
//               plus EXTEND and halt-word detection.
// Revision    : 1.0 - initial release
// ============================================================================
module agc_word_decode
    import agc_pkg::*;
#(
    parameter logic [14:0] EXTEND_WORD = C_EXTEND_WORD,
    parameter logic [11:0] HALT_ADDR   = C_HALT_ADDR
) (
    input  logic [14:0] word_i,
    output fields_t     fields_o,
    output logic        is_extend_o,
    output logic        is_halt_o
);

    always_comb begin
        fields_o.opcode = word_i[14:12];
        fields_o.qc     = word_i[11:10];
        fields_o.periph = word_i[9];
        fields_o.addr12 = word_i[11:0];
        fields_o.addr10 = word_i[9:0];
    end

    assign is_extend_o = (word_i == EXTEND_WORD);
    // Extracode qualification is applied by the caller, which owns ext_pending.
    assign is_halt_o   = (word_i[14:12] == C_OP_MASK) && (word_i[11:0] == HALT_ADDR);

endmodule
`default_nettype wire

// File: rtl/agc_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : agc_fetch_decode
// Description : AGC fetch/decode stage: PC, single-outstanding memory read,
//               EXTEND/INDEX folding and valid/ready issue to the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module agc_fetch_decode
    import agc_pkg::*;
#(
    parameter logic [11:0] RESET_PC    = C_RESET_PC,
    parameter logic [14:0] EXTEND_WORD = C_EXTEND_WORD,
    parameter logic [11:0] HALT_ADDR   = C_HALT_ADDR
) (
    input  logic                      clk,
    input  logic                      rst,
    agc_fetch_decode_if.master        fd
);

    state_e      state_q,       state_d;
    logic [11:0] pc_q,          pc_d;
    logic [14:0] raw_q,         raw_d;
    logic        ext_pend_q,    ext_pend_d;
    logic        idx_pend_q,    idx_pend_d;
    logic [14:0] idx_reg_q,     idx_reg_d;
    logic        drop_q,        drop_d;
    logic        mem_rd_q,      mem_rd_d;
    logic [11:0] mem_addr_q,    mem_addr_d;
    logic        issue_valid_q, issue_valid_d;
    fields_t     fields_q,      fields_d;
    logic        extracode_q,   extracode_d;
    logic [11:0] instr_pc_q,    instr_pc_d;
    logic        halt_q,        halt_d;

    logic        w_idx_used;
    logic [14:0] w_word;
    fields_t     w_fields;
    logic        w_is_extend;
    logic        w_is_halt;

    assign w_idx_used = idx_pend_q && (raw_q != EXTEND_WORD);
    assign w_word     = w_idx_used ? apply_index(raw_q, idx_reg_q) : raw_q;

    agc_word_decode #(
        .EXTEND_WORD (EXTEND_WORD),
        .HALT_ADDR   (HALT_ADDR)
    ) u_word_decode (
        .word_i      (w_word),
        .fields_o    (w_fields),
        .is_extend_o (w_is_extend),
        .is_halt_o   (w_is_halt)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        raw_d         = raw_q;
        ext_pend_d    = ext_pend_q;
        idx_pend_d    = idx_pend_q;
        idx_reg_d     = idx_reg_q;
        drop_d        = drop_q;
        mem_rd_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        issue_valid_d = issue_valid_q;
        fields_d      = fields_q;
        extracode_d   = extracode_q;
        instr_pc_d    = instr_pc_q;
        halt_d        = halt_q;

        if (fd.pc_load && (state_q != ST_HALT)) begin
            pc_d = fd.pc_load_val;
        end

        case (state_q)
            ST_FETCH: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = fd.pc_load ? fd.pc_load_val : pc_q;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A response during the strobe cycle can only be a stale one from before reset.
                if (fd.mem_rvalid && !mem_rd_q) begin
                    if (drop_q || fd.pc_load) begin
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        raw_d   = fd.mem_rdata;
                        state_d = ST_DECODE;
                    end
                end else if (fd.pc_load) begin
                    drop_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (fd.pc_load) begin
                    if (w_is_extend) begin
                        ext_pend_d = 1'b1;
                    end
                    state_d = ST_FETCH;
                end else begin
                    if (w_idx_used) begin
                        idx_pend_d = 1'b0;
                    end
                    if (w_is_extend) begin
                        ext_pend_d = 1'b1;
                        pc_d       = pc_q + 12'd1;
                        state_d    = ST_FETCH;
                    end else if (w_is_halt && !ext_pend_q) begin
                        halt_d  = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        fields_d      = w_fields;
                        extracode_d   = ext_pend_q;
                        instr_pc_d    = pc_q;
                        issue_valid_d = 1'b1;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (fd.issue_ready) begin
                    issue_valid_d = 1'b0;
                    ext_pend_d    = 1'b0;
                    pc_d          = fd.pc_load ? fd.pc_load_val : pc_q + 12'd1;
                    state_d       = ST_FETCH;
                end else if (fd.pc_load) begin
                    issue_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (fd.index_load) begin
            idx_reg_d  = fd.index_val;
            idx_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            raw_q         <= '0;
            ext_pend_q    <= 1'b0;
            idx_pend_q    <= 1'b0;
            idx_reg_q     <= '0;
            drop_q        <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            issue_valid_q <= 1'b0;
            fields_q      <= '0;
            extracode_q   <= 1'b0;
            instr_pc_q    <= '0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            raw_q         <= raw_d;
            ext_pend_q    <= ext_pend_d;
            idx_pend_q    <= idx_pend_d;
            idx_reg_q     <= idx_reg_d;
            drop_q        <= drop_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            issue_valid_q <= issue_valid_d;
            fields_q      <= fields_d;
            extracode_q   <= extracode_d;
            instr_pc_q    <= instr_pc_d;
            halt_q        <= halt_d;
        end
    end

    assign fd.mem_rd      = mem_rd_q;
    assign fd.mem_addr    = mem_addr_q;
    assign fd.issue_valid = issue_valid_q;
    assign fd.opcode      = fields_q.opcode;
    assign fd.qc          = fields_q.qc;
    assign fd.periph      = fields_q.periph;
    assign fd.addr12      = fields_q.addr12;
    assign fd.addr10      = fields_q.addr10;
    assign fd.extracode   = extracode_q;
    assign fd.instr_pc    = instr_pc_q;
    assign fd.halt        = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_agc_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_agc_fetch_decode
// Description : Scoreboard bench for agc_fetch_decode with a memory responder
//               and a program-walk reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_agc_fetch_decode;
    import agc_pkg::*;

    typedef struct {
        logic [14:0] word;
        logic        ext;
        logic [11:0] pc;
        logic        is_halt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    agc_fetch_decode_if bus ();

    agc_fetch_decode dut (
        .clk (clk),
        .rst (rst),
        .fd  (bus)
    );

    exp_t        exp_q[$];
    logic [14:0] mem [0:4095];
    logic [11:0] m_pc;
    logic        m_ext, m_idx_pend;
    logic [14:0] m_idx;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          rd_count = 0;
    logic [11:0] last_rd_addr = '0;
    logic        halt_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] exp_fields(input logic [14:0] w);
        return {w[14:12], w[11:10], w[9], w[11:0], w[9:0]};
    endfunction

    // Walk the program from m_pc: EXTENDs fold into the next word, a pending
    // index is added to the first non-EXTEND word, then push what must appear.
    function automatic void model_next();
        logic [14:0] w;
        exp_t        e;
        for (int g = 0; g < 8192; g++) begin
            w = mem[m_pc];
            if (w != 15'h0006 && m_idx_pend) begin
                w          = w + m_idx;
                m_idx_pend = 1'b0;
            end
            if (w == 15'h0006) begin
                m_ext = 1'b1;
                m_pc  = m_pc + 12'd1;
                continue;
            end
            e.word    = w;
            e.ext     = m_ext;
            e.pc      = m_pc;
            e.is_halt = (w == 15'h7FFF) && !m_ext;
            exp_q.push_back(e);
            return;
        end
        n_fail++;
        $display("FAIL model: no issuable word reachable from pc %0h", m_pc);
    endfunction

    // Memory responder: one read at a time, latency lat_min..lat_max cycles.
    initial begin
        int          cd;
        logic [11:0] a;
        cd = 0;
        a  = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
            if (rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = mem[a];
                    end
                end
                if (bus.mem_rd) begin
                    check("one_outstanding", 64'(cd), 64'(0));
                    rd_count++;
                    last_rd_addr = bus.mem_addr;
                    a  = bus.mem_addr;
                    cd = int'($urandom_range(lat_max, lat_min));
                end
            end
        end
    end

    // Monitor: compare every handshake and the halt rise against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                halt_seen = 1'b0;
            end else begin
                if (bus.issue_valid && bus.issue_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL issue_unexpected: got pc %0h, none expected", bus.instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_fields",
                              64'({bus.opcode, bus.qc, bus.periph, bus.addr12, bus.addr10, 1'b0}),
                              64'({exp_fields(e.word), e.is_halt}));
                        check("issue_extracode", 64'(bus.extracode), 64'(e.ext));
                        check("issue_instr_pc", 64'(bus.instr_pc), 64'(e.pc));
                    end
                end
                if (bus.halt && !halt_seen) begin
                    halt_seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL halt_unexpected: got halt=1, no halt expected");
                    end else begin
                        e = exp_q.pop_front();
                        check("halt_rise", 64'({bus.halt, bus.issue_valid}), 64'({e.is_halt, 1'b0}));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        bus.issue_ready = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_load_val = '0;
        bus.index_load  = 1'b0;
        bus.index_val   = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_outputs",
              64'({bus.mem_rd, bus.mem_addr, bus.issue_valid, bus.halt, bus.opcode, bus.qc,
                   bus.periph, bus.addr12, bus.addr10, bus.extracode, bus.instr_pc}),
              64'(0));
        exp_q.delete();
        m_pc = 12'h800; m_ext = 1'b0; m_idx_pend = 1'b0; m_idx = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rd(input int budget);
        int start;
        start = rd_count;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (rd_count != start) return;
        end
        n_checks++; n_fail++;
        $display("FAIL wait_rd: got no mem_rd, required one within %0d cycles", budget);
    endtask

    // Control-unit side: wait for an issue, stall, then accept with optional redirect/index.
    task automatic accept(input int stall, input logic do_pc, input logic [11:0] pcv,
                          input logic do_idx, input logic [14:0] idxv);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!bus.issue_valid) begin
            if (bus.halt) return;
            if (t >= 100) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: got issue_valid=0, required 1 within %0d cycles", t);
                return;
            end
            @(posedge clk); #1;
            t++;
        end
        for (int s = 0; s < stall; s++) begin
            if (exp_q.size() > 0)
                check("stall_hold",
                      64'({bus.issue_valid, bus.opcode, bus.qc, bus.periph, bus.addr12, bus.addr10,
                           bus.extracode, bus.instr_pc}),
                      64'({1'b1, exp_fields(exp_q[0].word), exp_q[0].ext, exp_q[0].pc}));
            @(posedge clk); #1;
        end
        bus.issue_ready = 1'b1;
        bus.pc_load     = do_pc;
        bus.pc_load_val = pcv;
        bus.index_load  = do_idx;
        bus.index_val   = idxv;
        m_ext = 1'b0;
        m_pc  = do_pc ? pcv : m_pc + 12'd1;
        if (do_idx) begin
            m_idx      = idxv;
            m_idx_pend = 1'b1;
        end
        model_next();
        @(posedge clk); #1;
        bus.issue_ready = 1'b0;
        bus.pc_load     = 1'b0;
        bus.index_load  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int start;
        logic [31:0] r;

        for (int i = 0; i < 4096; i++) mem[i] = 15'h1000;

        // Basic latency and field decode
        do_reset();
        mem[12'h800] = 15'o30012;
        mem[12'h801] = 15'h1234;
        model_next();
        wait_rd(10);
        check("t1_first_addr", 64'(last_rd_addr), 64'(12'h800));
        cyc = 0;
        while (!bus.issue_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t1_latency", 64'(cyc), 64'(3));
        check("t1_fields", 64'({bus.opcode, bus.addr12, bus.instr_pc, bus.extracode}),
              64'({3'd3, 12'h00A, 12'h800, 1'b0}));
        accept(0, 1'b0, '0, 1'b0, '0);
        wait_rd(10);
        check("t1_next_addr", 64'(last_rd_addr), 64'(12'h801));

        // EXTEND folds into the following word only
        do_reset();
        mem[12'h800] = 15'h0006;
        mem[12'h801] = 15'h6010;
        mem[12'h802] = 15'h1234;
        model_next();
        accept(0, 1'b0, '0, 1'b0, '0);
        accept(0, 1'b0, '0, 1'b0, '0);

        // INDEX applies to exactly one following word
        do_reset();
        mem[12'h800] = 15'h1111;
        mem[12'h801] = 15'h6010;
        mem[12'h802] = 15'h6010;
        model_next();
        accept(0, 1'b0, '0, 1'b1, 15'h0005);
        accept(0, 1'b0, '0, 1'b0, '0);
        accept(0, 1'b0, '0, 1'b0, '0);

        // INDEX wrap to zero, then a genuine halt word
        do_reset();
        mem[12'h800] = 15'h1111;
        mem[12'h801] = 15'h7FFF;
        mem[12'h802] = 15'h7FFF;
        model_next();
        accept(0, 1'b0, '0, 1'b1, 15'h0001);
        accept(0, 1'b0, '0, 1'b0, '0);
        cyc = 0;
        while (!bus.halt && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t4_halt", 64'(bus.halt), 64'(1));
        start = rd_count;
        repeat (20) @(posedge clk);
        #2;
        check("t4_no_fetch_after_halt", 64'({rd_count - start, 31'(0), bus.issue_valid}), 64'(0));

        // Redirect while waiting: late response discarded
        do_reset();
        lat_min = 3; lat_max = 3;
        mem[12'h800] = 15'h2222;
        mem[12'h123] = 15'h3333;
        wait_rd(10);
        bus.pc_load     = 1'b1;
        bus.pc_load_val = 12'h123;
        @(posedge clk); #1;
        bus.pc_load = 1'b0;
        m_pc = 12'h123;
        model_next();
        wait_rd(20);
        check("t5_redirect_addr", 64'(last_rd_addr), 64'(12'h123));
        accept(0, 1'b0, '0, 1'b0, '0);
        lat_min = 1; lat_max = 1;

        // Stall with stable outputs, redirect on handshake, then reset mid-WAIT
        do_reset();
        mem[12'h800] = 15'h4444;
        mem[12'h050] = 15'h5555;
        model_next();
        accept(5, 1'b1, 12'h050, 1'b0, '0);
        wait_rd(10);
        check("t6_redirect_addr", 64'(last_rd_addr), 64'(12'h050));
        do_reset();
        model_next();
        wait_rd(10);
        check("t6_restart_addr", 64'(last_rd_addr), 64'(12'h800));
        accept(0, 1'b0, '0, 1'b0, '0);

        // Randomised program with EXTENDs, redirects, indices and variable latency
        do_reset();
        for (int i = 0; i < 4096; i++) begin
            r = $urandom;
            mem[i] = ($urandom_range(7, 0) == 0) ? 15'h0006 : r[14:0];
        end
        lat_min = 1; lat_max = 3;
        model_next();
        for (int k = 0; k < 60; k++) begin
            if (bus.halt) break;
            r = $urandom;
            accept(int'($urandom_range(2, 0)), ($urandom_range(4, 0) == 0), r[11:0],
                   ($urandom_range(3, 0) == 0), r[26:12]);
        end
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
